time_set_controller: RTL
========================

Name: time_set_controller

Overview:
- Mode sequencer for the clock's time counter.
- Turns three raw user buttons (mode, increment, preset) into the counter's adjust-enable, per-field increment strobes, preset request and field-select LEDs.
- Cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, with an inactivity timeout back to RUN.
- Sits between the button inputs and the time counter and runs on the 1 Hz clock domain.

Parameters:
- TIMEOUT_S, 10: consecutive idle clk_1Hz cycles in a SET state before forced return to RUN. Legal range 2..63.

Ports:
- clk_1Hz  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  mode button level, synchronous to clk_1Hz.
- btn_inc  in  1  increment button level; held = 1 increment per cycle.
- btn_preset  in  1  preset button level.
- adj_en  out  1  high while in any SET state; drives counter adjust mode.
- inc_sec  out  1  one-cycle seconds increment strobe.
- inc_min  out  1  one-cycle minutes increment strobe.
- inc_hour  out  1  one-cycle hours increment strobe.
- preset_req  out  1  one-cycle request to load 23:59:50.
- sel_led  out  3  one-hot field select {hour,min,sec}; 000 in RUN.
- mode  out  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

Behaviour:
- All outputs are registered. No combinational input-to-output path.
- Reset (rst=0, asynchronous):
  - mode=RUN; adj_en, inc_*, preset_req=0; sel_led=000; idle counter=0.
  - Edge-detect history registers reset to 1, so a button held through reset release is not a press.
- Edge detect: press = btn_x==1 this edge and 0 at the previous edge, for btn_mode and btn_preset. btn_inc is level-sensitive.
- State transitions on mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. One step per press.
- adj_en = (next mode != RUN). sel_led is the one-hot of next mode. Both take effect at the same edge as the transition.
- Increment strobes:
  - At an edge with current mode SET_x, btn_inc=1 and no mode press: inc_x <= 1 for one cycle. All other inc_* <= 0.
  - Outputs are one-hot or zero and never assert in RUN.
  - Mode press and btn_inc at the same edge: the press wins and no increment is issued.
  - Held btn_inc gives one strobe per cycle, i.e. 1 Hz auto-repeat.
- Preset:
  - In RUN, a btn_preset press sets preset_req <= 1 for one cycle.
  - Ignored in SET states.
  - Preset press and mode press at the same edge in RUN: the mode transition wins and preset is dropped (no queuing).
- Idle timeout:
  - Counter width is 6 bits.
  - Counter is cleared on any mode press, any btn_inc=1 edge in a SET state, and in RUN.
  - Otherwise, in a SET state, it increments each edge.
  - When counter==TIMEOUT_S-1 and no activity at that edge: mode <= RUN, adj_en <= 0, sel_led <= 000, counter <= 0.
  - Activity at that same edge takes priority; the timeout is not taken.
- Reset mid-operation: an immediate return to the reset values. Any strobe in flight is cancelled.
- The counter-side wrap (59->0, 23->0) is the time counter's job. This block only issues strobes.

Test Plan:
- Reset with btn_mode held high, then release rst: mode=0 and adj_en=0 at the first 3 edges. Drop btn_mode, raise it again: mode=1, sel_led=100, adj_en=1.
- 4 isolated mode presses: mode goes 1,2,3,0 and sel_led goes 100,010,001,000. adj_en falls at the 4th press.
- In SET_MIN, hold btn_inc for 5 edges: inc_min=1 on exactly 5 cycles and inc_sec=inc_hour=0 throughout. Then mode press with btn_inc=1 on the same edge: mode=3, no strobe.
- TIMEOUT_S=10: enter SET_HOUR and stay idle. mode stays 1 for 9 edges and becomes 0 on the 10th. Repeat with btn_inc pulsed on idle edge 9: timeout restarts and the return occurs 10 edges after the pulse.
- In RUN, btn_preset press: preset_req=1 for exactly 1 cycle. Preset press in SET_SEC: preset_req stays 0. Preset and mode press on the same edge in RUN: mode=1, preset_req=0.
- Assert rst low asynchronously between edges while in SET_SEC with inc_sec=1: all outputs 0 and mode=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/time_set_controller.sv
// Mode sequencer for the time counter: turns raw mode/inc/preset buttons into
// adjust-enable, per-field increment strobes, preset request and field LEDs.
module time_set_controller #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_preset,
  output logic       adj_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       preset_req,
  output logic [2:0] sel_led,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

  state_t     state_q, state_d;
  logic [5:0] idle_q, idle_d;
  logic       mode_hist_q, preset_hist_q;
  logic       adj_en_q, adj_en_d;
  logic [2:0] inc_q, inc_d;          // {hour, min, sec}
  logic       preset_req_q, preset_req_d;
  logic [2:0] sel_led_q, sel_led_d;

  logic mode_press, preset_press, in_set, timeout_hit;

  always_comb begin
    mode_press   = btn_mode & ~mode_hist_q;
    preset_press = btn_preset & ~preset_hist_q;
    in_set       = (state_q != RUN);
    // Any activity at the expiry edge keeps us in the SET state.
    timeout_hit  = in_set & ~mode_press & ~btn_inc & (idle_q == IDLE_LAST);

    state_d = state_q;
    if (mode_press) begin
      state_d = state_t'(state_q + 2'd1);
    end else if (timeout_hit) begin
      state_d = RUN;
    end

    idle_d = idle_q + 6'd1;
    if (!in_set || mode_press || btn_inc || timeout_hit) begin
      idle_d = '0;
    end

    inc_d = 3'b000;
    if (in_set && btn_inc && !mode_press) begin
      case (state_q)
        SET_HOUR: inc_d = 3'b100;
        SET_MIN:  inc_d = 3'b010;
        SET_SEC:  inc_d = 3'b001;
        default:  inc_d = 3'b000;
      endcase
    end

    preset_req_d = ~in_set & preset_press & ~mode_press;
    adj_en_d     = (state_d != RUN);

    case (state_d)
      SET_HOUR: sel_led_d = 3'b100;
      SET_MIN:  sel_led_d = 3'b010;
      SET_SEC:  sel_led_d = 3'b001;
      default:  sel_led_d = 3'b000;
    endcase
  end

  // History flops reset high so a button held through reset is not a press.
  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      idle_q        <= '0;
      mode_hist_q   <= 1'b1;
      preset_hist_q <= 1'b1;
      adj_en_q      <= 1'b0;
      inc_q         <= 3'b000;
      preset_req_q  <= 1'b0;
      sel_led_q     <= 3'b000;
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      mode_hist_q   <= btn_mode;
      preset_hist_q <= btn_preset;
      adj_en_q      <= adj_en_d;
      inc_q         <= inc_d;
      preset_req_q  <= preset_req_d;
      sel_led_q     <= sel_led_d;
    end
  end

  assign mode       = state_q;
  assign adj_en     = adj_en_q;
  assign inc_hour   = inc_q[2];
  assign inc_min    = inc_q[1];
  assign inc_sec    = inc_q[0];
  assign preset_req = preset_req_q;
  assign sel_led    = sel_led_q;

endmodule
